// File: rtl/traffic_log_arbiter.sv
// Round-robin arbiter funnelling per-port monitor records into a small FIFO drained by one log writer.
// Optional per-record sequence numbering is enabled by defining TRAFFIC_LOG_ARB_SEQ_EN.
module traffic_log_arbiter #(
   parameter  int NUM_REQ   = 5,
   parameter  int REC_WIDTH = 256,
   parameter  int DEPTH     = 4,
   localparam int SRC_W     = $clog2(NUM_REQ)
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [NUM_REQ-1:0]           req_i,
   input  logic [NUM_REQ*REC_WIDTH-1:0] rec_i,
   output logic [NUM_REQ-1:0]           ack_o,
   output logic                         valid_o,
   output logic [REC_WIDTH-1:0]         rec_o,
   output logic [SRC_W-1:0]             src_o,
   input  logic                         ready_i,
   output logic [31:0]                  stall_cycles_o
`ifdef TRAFFIC_LOG_ARB_SEQ_EN
   ,
   output logic [31:0]                  seq_o
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   logic [SRC_W-1:0]     r_rr;
   logic [PTR_W-1:0]     r_wr;
   logic [PTR_W-1:0]     r_rd;
   logic [CNT_W-1:0]     r_cnt;
   logic [31:0]          r_stall;
   logic [REC_WIDTH-1:0] r_mem_rec [DEPTH];
   logic [SRC_W-1:0]     r_mem_src [DEPTH];
`ifdef TRAFFIC_LOG_ARB_SEQ_EN
   logic [31:0]          r_seq;
   logic [31:0]          r_mem_seq [DEPTH];
`endif

   logic [SRC_W:0]   w_sum;
   logic [SRC_W-1:0] w_win;
   logic [SRC_W-1:0] w_rr_nxt;
   logic             w_found;
   logic             w_full;
   logic             w_push;
   logic             w_pop;

   // Rotating priority search starting at the registered pointer
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_sum   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_sum = {1'b0, r_rr} + (SRC_W+1)'(k);
         if (w_sum >= (SRC_W+1)'(NUM_REQ))
            w_sum = w_sum - (SRC_W+1)'(NUM_REQ);
         if (!w_found && req_i[w_sum[SRC_W-1:0]]) begin
            w_found = 1'b1;
            w_win   = w_sum[SRC_W-1:0];
         end
      end
   end

   // Full blocks grants even when popping, keeping ready_i off the ack_o path
   assign w_full   = (r_cnt == CNT_W'(DEPTH));
   assign w_push   = w_found && !w_full && rst_ni;
   assign w_pop    = (r_cnt != '0) && ready_i;
   assign w_rr_nxt = (w_win == SRC_W'(NUM_REQ - 1)) ? '0 : w_win + SRC_W'(1);
   assign ack_o    = w_push ? (NUM_REQ'(1) << w_win) : '0;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_rr    <= '0;
         r_wr    <= '0;
         r_rd    <= '0;
         r_cnt   <= '0;
         r_stall <= '0;
`ifdef TRAFFIC_LOG_ARB_SEQ_EN
         r_seq   <= '0;
`endif
      end else begin
         if (w_push) begin
            r_wr <= r_wr + PTR_W'(1);
            r_rr <= w_rr_nxt;
`ifdef TRAFFIC_LOG_ARB_SEQ_EN
            r_seq <= r_seq + 32'd1;
`endif
         end
         if (w_pop)
            r_rd <= r_rd + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CNT_W'(1);
            2'b01:   r_cnt <= r_cnt - CNT_W'(1);
            default: r_cnt <= r_cnt;
         endcase
         if ((|req_i) && w_full)
            r_stall <= sat_inc(r_stall);
      end
   end

   // Record storage carries no reset; only the pointers decide what is live
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem_rec[r_wr] <= rec_i[int'(w_win)*REC_WIDTH +: REC_WIDTH];
         r_mem_src[r_wr] <= w_win;
`ifdef TRAFFIC_LOG_ARB_SEQ_EN
         r_mem_seq[r_wr] <= r_seq;
`endif
      end
   end

   assign valid_o        = (r_cnt != '0);
   assign rec_o          = valid_o ? r_mem_rec[r_rd] : '0;
   assign src_o          = valid_o ? r_mem_src[r_rd] : '0;
   assign stall_cycles_o = r_stall;
`ifdef TRAFFIC_LOG_ARB_SEQ_EN
   assign seq_o          = valid_o ? r_mem_seq[r_rd] : '0;
`endif

endmodule

// File: doc/traffic_log_arbiter.md
Name: traffic_log_arbiter

Overview:
- Shares a single traffic-log writer between the per-port link monitors of one Hermes router. The router has one monitor per port, and each monitor produces one completed-message record.
- Round-robin grants monitors into a small record FIFO. The FIFO drains to one consumer, the simulation log writer, over a valid/ready handshake.
- Removes the concurrent open/append contention on the shared traffic log.
- Records are opaque bit vectors; field packing is owned by the monitors and the writer.

Parameters:
- NUM_REQ, 5, number of requesting monitors (one per hermes_port_t value); range 2..8.
- REC_WIDTH, 256, record width in bits.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- SRC_W, $clog2(NUM_REQ), width of source index (derived, not overridable).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset, sampled on posedge clk_i
- req_i  in  NUM_REQ  per-monitor record valid; held with record stable until acked
- rec_i  in  NUM_REQ*REC_WIDTH  records, requester i at [i*REC_WIDTH +: REC_WIDTH]
- ack_o  out  NUM_REQ  one-hot grant; transfer from i on the edge where req_i[i] && ack_o[i]
- valid_o  out  1  FIFO head valid
- rec_o  out  REC_WIDTH  FIFO head record
- src_o  out  SRC_W  requester index of head record
- ready_i  in  1  writer accepts head; pop on valid_o && ready_i
- stall_cycles_o  out  32  saturating count of cycles with any req_i high and FIFO full

Behaviour:
- Reset (rst_ni low at posedge):
  - FIFO empty: count=0, rd/wr pointers=0.
  - RR pointer=0.
  - stall_cycles_o=0, valid_o=0, rec_o=0, src_o=0, ack_o=0.
- Reset mid-operation discards all queued records. Requesters still holding req_i are re-arbitrated after reset.
- Arbitration is combinational from the registered RR pointer p:
  - Search order is p, p+1, ..., NUM_REQ-1, 0, ..., p-1.
  - The first i with req_i[i]=1 wins.
  - ack_o[i]=1 for the winner only, and only if count<DEPTH; otherwise ack_o=0.
- Push on the edge with any ack bit set:
  - rec_i slice and winner index are written at wr_ptr.
  - wr_ptr increments, wrapping modulo DEPTH.
  - p <= winner+1, wrapping from NUM_REQ-1 to 0.
- When nothing is pushed, p is unchanged.
- Pop on valid_o && ready_i: rd_ptr increments, wrapping modulo DEPTH.
- valid_o = (count!=0). rec_o and src_o are driven from the entry at rd_ptr.
- rec_o and src_o may hold stale data when valid_o=0; the spec only requires them after reset.
- Latency: a record pushed on edge N appears on valid_o after edge N. No bypass path.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Full (count==DEPTH):
  - No grant, even if a pop happens in the same cycle.
  - This avoids a combinational ready_i-to-ack_o path.
  - Capacity frees on the following cycle.
- Empty with ready_i high: no pop, pointers hold.
- stall_cycles_o:
  - Increments by 1 on each edge where (|req_i) && count==DEPTH.
  - Saturates at 32'hFFFF_FFFF; never wraps.
  - Cleared only by reset.
- A requester that drops req_i without being acked loses its slot. This is legal and no record is pushed for it.
- Fairness: with all requesters continuously asserting and the FIFO never full, grants rotate 0,1,...,NUM_REQ-1,0,... One grant per cycle maximum.
- Throughput: one push and one pop per cycle sustained.

Optional Feature:
- Macro: TRAFFIC_LOG_ARB_SEQ_EN.
- When defined:
  - Adds output seq_o (32 bits), carried per FIFO entry alongside the record.
  - Global sequence counter, reset to 0, increments on every push and wraps to 0 after 32'hFFFF_FFFF.
  - Each pushed entry stores the pre-increment counter value.
  - seq_o shows the head entry's stored value, letting the writer detect drops and reordering.
- When undefined: the seq_o port, counter and per-entry storage are absent. All other behaviour is identical.

Test Plan:
1. Reset, then req_i=5'b00100, rec slice 2=256'hA5, ready_i=1 -> ack_o=5'b00100 for one cycle; next cycle valid_o=1, rec_o=256'hA5, src_o=2; following cycle valid_o=0.
2. All five req_i held high, ready_i=1, 10 records each -> grant order 0,1,2,3,4,0,... and src_o sequence matches; no requester ever granted twice while another is waiting.
3. ready_i=0, req_i=5'b11111 held -> exactly 4 acks (src 0..3), then ack_o=0; stall_cycles_o increments by 1 per cycle from the cycle after the 4th push; raise ready_i -> one pop, the next cycle grants requester 4.
4. Full FIFO with ready_i=1 and req_i pending -> no ack in the pop cycle; ack on the next cycle; count stays ≤4 throughout.
5. Force stall_cycles_o to 32'hFFFF_FFFE (or run long) under a full stall -> reaches 32'hFFFF_FFFF and holds.
6. Three records queued, rst_ni low for one edge -> valid_o=0, stall_cycles_o=0, next grant starts from requester 0. With TRAFFIC_LOG_ARB_SEQ_EN, seq_o restarts at 0.
